mem_word_transfer: RTL and testbench
====================================

# mem_word_transfer

Multi-byte load/store sequencer between the 32-bit datapath and the byte-wide memory. It replaces microcode-stepped MuxCSel byte selection and DR shifting with one request/complete handshake. A single request moves 1..DATA_BYTES bytes at consecutive addresses, with optional sign extension on loads. It sits beside the DR/IR load path and drives the memory address, data, WR and CS pins while busy.

## Interface
- DATA_BYTES, 4, maximum bytes per transfer (≥1); word width W = 8*DATA_BYTES
- ADDR_WIDTH, 16, memory address width
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Start  in  1  request strobe; accepted only when Busy=0
- Write  in  1  1 = store, 0 = load; sampled with Start
- Count  in  $clog2(DATA_BYTES)+1  bytes to move; legal 1..DATA_BYTES
- SignExt  in  1  load only: sign-extend result above byte Count-1
- BaseAddr  in  ADDR_WIDTH  address of first byte
- WData  in  W  store data; low Count bytes used
- RData  out  W  load result; held until the next load completes
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle completion pulse
- Err  out  1  valid with Done; 1 = request rejected
- Mem_Address  out  ADDR_WIDTH  memory address
- Mem_Data  out  8  store byte
- Mem_WR  out  1  1 = write
- Mem_CS  out  1  chip select, active-low
- MemOut  in  8  memory read data; synchronous read, valid the cycle after the address

## Operation
- All request inputs are latched at accept. Later input changes do not affect the transfer.
- FSM states:
  - IDLE: accepts Start. An illegal Count (0 or >DATA_BYTES) goes to DONE with Err=1 and makes no memory access.
  - WRITE: drives byte i to address i for i = 0..N-1, then goes to DONE.
  - READ: issues addresses i = 0..N-1 and captures each byte one cycle after its address, then goes to DONE.
  - DONE: Done=1, then returns to IDLE.
- Address for byte i is BaseAddr+i modulo 2^ADDR_WIDTH; wrap-around is legal.
- Byte order (default, little-endian): byte i ↔ WData/RData[8i+7:8i].
- Load result: bytes ≥N are 0, or copies of bit 8N-1 when SignExt=1.
- Mem_CS=0 only in cycles that drive a valid address. Mem_WR=1 only in WRITE.
- Start while Busy=1 is ignored, with no queueing.
- Start in the DONE cycle (Busy=0) is accepted and runs back to back.

## Timing
- Cycle 0 is the edge that samples Start. The first memory access occurs in cycle 1.
- Store of N bytes:
  - Busy=1 in cycles 1..N.
  - Each byte is written at the edge ending its cycle.
  - Done=1, Busy=0 in cycle N+1.
- Load of N bytes:
  - Addresses are driven in cycles 1..N; MemOut is captured at the end of cycles 2..N+1.
  - Busy=1 in cycles 1..N+1.
  - RData updates at the end of cycle N+1; Done=1 in cycle N+2.
- Rejected request: Done=1, Err=1 in cycle 1. Busy never rises and RData is unchanged.
- Reset values: Busy=0, Done=0, Err=0, RData=0, Mem_Address=0, Mem_Data=0, Mem_WR=0, Mem_CS=1.
- Idle: Mem_Address holds its last value.
- Reset mid-transfer aborts it next edge:
  - Bytes already written stay in memory.
  - No Done is produced.
  - Start is accepted in the first cycle after Reset deasserts.

## Configuration
- MWT_BIG_ENDIAN_EN undefined: little-endian as above.
- MWT_BIG_ENDIAN_EN defined:
  - Byte at BaseAddr+i ↔ data byte N-1-i, so the most significant of the N bytes sits at the lowest address.
  - Extension above byte N-1 is unchanged.
  - Timing is unchanged.

## Test plan
All scenarios use DATA_BYTES=4, ADDR_WIDTH=16.
- Store: N=4, WData=0xA1B2C3D4, BaseAddr=0x0010 → mem[0x10..0x13]=D4,C3,B2,A1; Done in cycle 5; Mem_CS=1 in cycle 5.
- Load from the previous contents: N=2, SignExt=1 → RData=0xFFFFC3D4; with SignExt=0 → 0x0000C3D4; Done in cycle 4.
- Wrap: store N=4 at 0xFFFE → Mem_Address sequence FFFE, FFFF, 0000, 0001.
- Count=5 or Count=0 → Done=1, Err=1 in cycle 1; Mem_CS stays 1; RData unchanged. A Start pulsed during a Busy load is ignored.
- Reset asserted in cycle 2 of a 4-byte store of 0x11223344 at 0x0020 → only mem[0x20]=44 changes; Busy=0 in cycle 3; no Done.
- Build with MWT_BIG_ENDIAN_EN: store N=4 of 0xA1B2C3D4 at 0x0010 → mem[0x10..0x13]=A1,B2,C3,D4; loading it back gives 0xA1B2C3D4.

Source files
------------

// File: rtl/mem_word_transfer_if.sv
// Request/response and byte-memory pins of mem_word_transfer.
// The sequencer uses the slave modport; the requester/memory side uses master.
interface mem_word_transfer_if #(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned ADDR_WIDTH = 16
);
   localparam int unsigned W  = 8 * DATA_BYTES;
   localparam int unsigned CW = $clog2(DATA_BYTES) + 1;

   logic                  Start;
   logic                  Write;
   logic [CW-1:0]         Count;
   logic                  SignExt;
   logic [ADDR_WIDTH-1:0] BaseAddr;
   logic [W-1:0]          WData;
   logic [W-1:0]          RData;
   logic                  Busy;
   logic                  Done;
   logic                  Err;
   logic [ADDR_WIDTH-1:0] Mem_Address;
   logic [7:0]            Mem_Data;
   logic                  Mem_WR;
   logic                  Mem_CS;
   logic [7:0]            MemOut;

   modport master (
      output Start, Write, Count, SignExt, BaseAddr, WData, MemOut,
      input  RData, Busy, Done, Err, Mem_Address, Mem_Data, Mem_WR, Mem_CS
   );

   modport slave (
      input  Start, Write, Count, SignExt, BaseAddr, WData, MemOut,
      output RData, Busy, Done, Err, Mem_Address, Mem_Data, Mem_WR, Mem_CS
   );
endinterface

// File: rtl/mem_word_transfer.sv
// Multi-byte load/store sequencer between the word datapath and byte-wide memory.
// Define MWT_BIG_ENDIAN_EN to place the most significant transferred byte at the lowest address.
module mem_word_transfer #(
   parameter int unsigned DATA_BYTES = 4,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input logic                Clock,
   input logic                Reset,
   mem_word_transfer_if.slave bus
);
   localparam int unsigned W  = 8 * DATA_BYTES;
   localparam int unsigned CW = $clog2(DATA_BYTES) + 1;
   localparam int unsigned SW = CW + 3;

`ifdef MWT_BIG_ENDIAN_EN
   localparam bit BigEndian = 1'b1;
`else
   localparam bit BigEndian = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

   state_t                state, stateNext;
   logic [CW-1:0]         idx, idxNext, idxInc;
   logic [CW-1:0]         countQ, countNext;
   logic                  signExtQ, signExtNext;
   logic [ADDR_WIDTH-1:0] baseQ, baseNext;
   logic [W-1:0]          wdataQ, wdataNext;
   logic [W-1:0]          accQ, accNext;
   logic [W-1:0]          rdataQ, rdataNext;
   logic                  busyQ, busyNext;
   logic                  doneQ, doneNext;
   logic                  errQ, errNext;
   logic [ADDR_WIDTH-1:0] addrQ, addrNext;
   logic [7:0]            mdataQ, mdataNext;
   logic                  wrQ, wrNext;
   logic                  csQ, csNext;
   logic                  countLegal;
   logic [SW-1:0]         nBits;
   logic [W-1:0]          lowMask, signMask;

   // Data-byte lane that pairs with the transfer's i-th memory address.
   function automatic logic [CW-1:0] bytePos(input logic [CW-1:0] i, input logic [CW-1:0] n);
      return BigEndian ? CW'(n - i - CW'(1)) : i;
   endfunction

   assign idxInc     = idx + CW'(1);
   assign countLegal = (bus.Count != '0) && (bus.Count <= CW'(DATA_BYTES));
   assign nBits      = {countQ, 3'b000};
   assign lowMask    = ~({W{1'b1}} << nBits);
   assign signMask   = W'(1) << (nBits - SW'(1));

   always_comb begin
      stateNext   = state;
      idxNext     = idx;
      countNext   = countQ;
      signExtNext = signExtQ;
      baseNext    = baseQ;
      wdataNext   = wdataQ;
      accNext     = accQ;
      rdataNext   = rdataQ;
      busyNext    = busyQ;
      doneNext    = 1'b0;
      errNext     = 1'b0;
      addrNext    = addrQ;
      mdataNext   = mdataQ;
      wrNext      = wrQ;
      csNext      = csQ;

      case (state)
         IDLE, DONE: begin
            stateNext = IDLE;
            if (bus.Start) begin
               countNext   = bus.Count;
               signExtNext = bus.SignExt;
               baseNext    = bus.BaseAddr;
               wdataNext   = bus.WData;
               if (countLegal) begin
                  idxNext  = '0;
                  accNext  = '0;
                  busyNext = 1'b1;
                  addrNext = bus.BaseAddr;
                  csNext   = 1'b0;
                  if (bus.Write) begin
                     stateNext = WRITE;
                     wrNext    = 1'b1;
                     mdataNext = 8'(bus.WData >> {bytePos(CW'(0), bus.Count), 3'b000});
                  end else begin
                     stateNext = READ;
                  end
               end else begin
                  // Rejected request: completion with error, no memory access.
                  stateNext = DONE;
                  doneNext  = 1'b1;
                  errNext   = 1'b1;
               end
            end
         end

         WRITE: begin
            if (idxInc < countQ) begin
               idxNext   = idxInc;
               addrNext  = baseQ + ADDR_WIDTH'(idxInc);
               mdataNext = 8'(wdataQ >> {bytePos(idxInc, countQ), 3'b000});
            end else begin
               stateNext = DONE;
               busyNext  = 1'b0;
               doneNext  = 1'b1;
               csNext    = 1'b1;
               wrNext    = 1'b0;
            end
         end

         READ: begin
            // Address i goes out at idx=i; its data arrives one cycle later at idx=i+1.
            idxNext = idxInc;
            if (idx != '0)
               accNext = accQ | (W'(bus.MemOut) << {bytePos(idx - CW'(1), countQ), 3'b000});
            if (idxInc < countQ)
               addrNext = baseQ + ADDR_WIDTH'(idxInc);
            else
               csNext = 1'b1;
            if (idx == countQ) begin
               stateNext = DONE;
               busyNext  = 1'b0;
               doneNext  = 1'b1;
               rdataNext = (accNext & lowMask)
                         | ((signExtQ && ((accNext & signMask) != '0)) ? ~lowMask : '0);
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         idx      <= '0;
         countQ   <= '0;
         signExtQ <= 1'b0;
         baseQ    <= '0;
         wdataQ   <= '0;
         accQ     <= '0;
         rdataQ   <= '0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
         errQ     <= 1'b0;
         addrQ    <= '0;
         mdataQ   <= '0;
         wrQ      <= 1'b0;
         csQ      <= 1'b1;
      end else begin
         state    <= stateNext;
         idx      <= idxNext;
         countQ   <= countNext;
         signExtQ <= signExtNext;
         baseQ    <= baseNext;
         wdataQ   <= wdataNext;
         accQ     <= accNext;
         rdataQ   <= rdataNext;
         busyQ    <= busyNext;
         doneQ    <= doneNext;
         errQ     <= errNext;
         addrQ    <= addrNext;
         mdataQ   <= mdataNext;
         wrQ      <= wrNext;
         csQ      <= csNext;
      end
   end

   // Reset deselects memory at once so an aborted store writes nothing more.
   assign bus.Mem_CS      = csQ | Reset;
   assign bus.Mem_WR      = wrQ & ~Reset;
   assign bus.Mem_Address = addrQ;
   assign bus.Mem_Data    = mdataQ;
   assign bus.RData       = rdataQ;
   assign bus.Busy        = busyQ;
   assign bus.Done        = doneQ;
   assign bus.Err         = errQ;
endmodule

// File: tb/tb_mem_word_transfer.sv
// Directed bench for mem_word_transfer against a synchronous byte-memory model.
// Expected values follow the byte order selected by MWT_BIG_ENDIAN_EN.
module tb_mem_word_transfer;
`ifdef MWT_BIG_ENDIAN_EN
   localparam bit BE = 1'b1;
`else
   localparam bit BE = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   mem_word_transfer_if #(.DATA_BYTES(4), .ADDR_WIDTH(16)) bus ();

   mem_word_transfer #(.DATA_BYTES(4), .ADDR_WIDTH(16)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Synchronous-read byte memory.
   logic [7:0] mem [0:65535];
   logic [7:0] memOut = 8'h00;
   always @(posedge Clock) begin
      if (!bus.Mem_CS) begin
         if (bus.Mem_WR) mem[bus.Mem_Address] <= bus.Mem_Data;
         memOut <= mem[bus.Mem_Address];
      end
   end
   assign bus.MemOut = memOut;

   int errors = 0;
   int checks = 0;

   int          doneCyc;
   int          busyCnt;
   int          nAddr;
   logic        errSeen;
   logic        csAtDone;
   logic [15:0] addrs [0:7];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request; returns in the Done cycle. pulseAt>0 raises a stray store Start in that cycle.
   task automatic runReq(input logic wr, input logic [2:0] cnt, input logic se,
                         input logic [15:0] base, input logic [31:0] wd, input int pulseAt);
      int cyc;
      @(negedge Clock);
      bus.Start = 1'b1; bus.Write = wr; bus.Count = cnt;
      bus.SignExt = se; bus.BaseAddr = base; bus.WData = wd;
      @(posedge Clock);
      @(negedge Clock);
      bus.Start = 1'b0; bus.Write = ~wr; bus.Count = 3'd1;
      bus.SignExt = ~se; bus.BaseAddr = ~base; bus.WData = ~wd;
      cyc = 1; doneCyc = 0; busyCnt = 0; nAddr = 0; errSeen = 1'b0; csAtDone = 1'b0;
      while (cyc < 20 && doneCyc == 0) begin
         if (!bus.Mem_CS && nAddr < 8) begin addrs[nAddr] = bus.Mem_Address; nAddr++; end
         if (bus.Busy) busyCnt++;
         if (bus.Done) begin
            doneCyc = cyc; errSeen = bus.Err; csAtDone = bus.Mem_CS;
         end else begin
            @(negedge Clock);
            cyc++;
            if (cyc == pulseAt) begin
               bus.Start = 1'b1; bus.Write = 1'b1; bus.Count = 3'd1;
               bus.BaseAddr = base; bus.WData = 32'h0000_00FF;
            end else begin
               bus.Start = 1'b0;
            end
         end
      end
      bus.Start = 1'b0;
   endtask

   initial begin
      bus.Start = 1'b0; bus.Write = 1'b0; bus.Count = 3'd0;
      bus.SignExt = 1'b0; bus.BaseAddr = 16'h0; bus.WData = 32'h0;
      repeat (3) @(negedge Clock);
      checkVal("rst_busy", 32'(bus.Busy), 32'd0);
      checkVal("rst_done", 32'(bus.Done), 32'd0);
      checkVal("rst_err",  32'(bus.Err), 32'd0);
      checkVal("rst_rdata", bus.RData, 32'h0);
      checkVal("rst_addr", 32'(bus.Mem_Address), 32'h0);
      checkVal("rst_mdata", 32'(bus.Mem_Data), 32'h0);
      checkVal("rst_wr", 32'(bus.Mem_WR), 32'd0);
      checkVal("rst_cs", 32'(bus.Mem_CS), 32'd1);
      Reset = 1'b0;

      // Full-width store.
      runReq(1'b1, 3'd4, 1'b0, 16'h0010, 32'hA1B2C3D4, 0);
      checkVal("st4_done_cyc", 32'(doneCyc), 32'd5);
      checkVal("st4_err", 32'(errSeen), 32'd0);
      checkVal("st4_busy_cycles", 32'(busyCnt), 32'd4);
      checkVal("st4_cs_at_done", 32'(csAtDone), 32'd1);
      checkVal("st4_naddr", 32'(nAddr), 32'd4);
      checkVal("st4_mem10", 32'(mem[16'h10]), BE ? 32'hA1 : 32'hD4);
      checkVal("st4_mem11", 32'(mem[16'h11]), BE ? 32'hB2 : 32'hC3);
      checkVal("st4_mem12", 32'(mem[16'h12]), BE ? 32'hC3 : 32'hB2);
      checkVal("st4_mem13", 32'(mem[16'h13]), BE ? 32'hD4 : 32'hA1);

      // Two-byte signed load with a stray Start while busy.
      runReq(1'b0, 3'd2, 1'b1, 16'h0010, 32'h0, 2);
      checkVal("ld2s_done_cyc", 32'(doneCyc), 32'd4);
      checkVal("ld2s_busy_cycles", 32'(busyCnt), 32'd3);
      checkVal("ld2s_rdata", bus.RData, BE ? 32'hFFFFA1B2 : 32'hFFFFC3D4);
      repeat (3) begin
         @(negedge Clock);
         checkVal("ignored_start_busy", 32'(bus.Busy), 32'd0);
      end

      runReq(1'b0, 3'd2, 1'b0, 16'h0010, 32'h0, 0);
      checkVal("ld2u_rdata", bus.RData, BE ? 32'h0000A1B2 : 32'h0000C3D4);

      runReq(1'b0, 3'd4, 1'b1, 16'h0010, 32'h0, 0);
      checkVal("ld4_done_cyc", 32'(doneCyc), 32'd6);
      checkVal("ld4_rdata", bus.RData, 32'hA1B2C3D4);

      // Address wrap-around.
      runReq(1'b1, 3'd4, 1'b0, 16'hFFFE, 32'h55667788, 0);
      checkVal("wrap_naddr", 32'(nAddr), 32'd4);
      checkVal("wrap_a0", 32'(addrs[0]), 32'hFFFE);
      checkVal("wrap_a1", 32'(addrs[1]), 32'hFFFF);
      checkVal("wrap_a2", 32'(addrs[2]), 32'h0000);
      checkVal("wrap_a3", 32'(addrs[3]), 32'h0001);
      checkVal("wrap_memFFFE", 32'(mem[16'hFFFE]), BE ? 32'h55 : 32'h88);
      checkVal("wrap_mem0001", 32'(mem[16'h0001]), BE ? 32'h88 : 32'h55);

      // Illegal counts.
      runReq(1'b0, 3'd5, 1'b1, 16'h0010, 32'h0, 0);
      checkVal("cnt5_done_cyc", 32'(doneCyc), 32'd1);
      checkVal("cnt5_err", 32'(errSeen), 32'd1);
      checkVal("cnt5_naddr", 32'(nAddr), 32'd0);
      checkVal("cnt5_busy", 32'(busyCnt), 32'd0);
      checkVal("cnt5_rdata", bus.RData, 32'hA1B2C3D4);
      runReq(1'b1, 3'd0, 1'b0, 16'h0010, 32'h12345678, 0);
      checkVal("cnt0_done_cyc", 32'(doneCyc), 32'd1);
      checkVal("cnt0_err", 32'(errSeen), 32'd1);
      checkVal("cnt0_naddr", 32'(nAddr), 32'd0);
      checkVal("cnt0_mem10", 32'(mem[16'h10]), BE ? 32'hA1 : 32'hD4);

      // Reset in cycle 2 of a store aborts after the first byte.
      runReq(1'b1, 3'd4, 1'b0, 16'h0020, 32'hEEEEEEEE, 0);
      @(negedge Clock);
      bus.Start = 1'b1; bus.Write = 1'b1; bus.Count = 3'd4;
      bus.SignExt = 1'b0; bus.BaseAddr = 16'h0020; bus.WData = 32'h11223344;
      @(negedge Clock);
      bus.Start = 1'b0;
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      checkVal("abort_busy", 32'(bus.Busy), 32'd0);
      checkVal("abort_done", 32'(bus.Done), 32'd0);
      checkVal("abort_cs", 32'(bus.Mem_CS), 32'd1);
      repeat (3) begin
         @(negedge Clock);
         checkVal("abort_no_done", 32'(bus.Done), 32'd0);
      end
      checkVal("abort_mem20", 32'(mem[16'h20]), BE ? 32'h11 : 32'h44);
      checkVal("abort_mem21", 32'(mem[16'h21]), 32'hEE);
      checkVal("abort_mem22", 32'(mem[16'h22]), 32'hEE);
      checkVal("abort_mem23", 32'(mem[16'h23]), 32'hEE);

      runReq(1'b0, 3'd3, 1'b1, 16'h0021, 32'h0, 0);
      checkVal("ld3s_rdata", bus.RData, 32'hFFEEEEEE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
